// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment display path.
// Pure definitions: no logic, no latency, no backpressure.
package seg7_pkg;

    localparam int NDIG = 4;

    localparam logic [7:0]      SEG_OFF = 8'h00;
    localparam logic [NDIG-1:0] DIG_OFF = 4'hF;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_t;

    // Active-low one-cold digit select for digit idx.
    function automatic logic [NDIG-1:0] dig_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot timer: cnt/idx scan counters with the BLANK/ON slot state and frame-end flag.
// state/idx are registered; frame_end is decoded from the current counters; no backpressure.
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 27_000,
    parameter int BLANK_CYCLES = 270
) (
    input  logic        clk,
    input  logic        rst,
    output slot_state_t state,
    output logic [1:0]  idx,
    output logic        frame_end
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    slot_state_t   state_q, state_d;
    logic          wrap;

    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        // State tracks the next counter value so it always matches the decode of cnt_q.
        state_d = (cnt_d < CNT_BLANK) ? BLANK : ON;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    assign state     = state_q;
    assign idx       = idx_q;
    assign frame_end = wrap && (idx_q == 2'(NDIG - 1));

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes four double-buffered segment patterns onto shared seg/dig pins with blanking gaps.
// Pins lag the slot state by one cycle; no backpressure. SEG7_DIM_EN adds 3-bit PWM dimming via bright.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 27_000,
    parameter int BLANK_CYCLES = 270
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_in,
    input  logic        load,
    input  logic [3:0]  dig_en,
    input  logic [2:0]  bright,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic        frame_tick
);

    slot_state_t state;
    logic [1:0]  idx;
    logic        frame_end;

    seg7_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .idx       (idx),
        .frame_end (frame_end)
    );

    logic [31:0] active_q, active_d;
    logic [31:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  dig_q, dig_d;
    logic        frame_tick_q, frame_tick_d;
    logic        lit;

`ifdef SEG7_DIM_EN
    logic [2:0] pwm_q, pwm_d;
    assign pwm_d = pwm_q + 3'd1;
    assign lit   = (state == ON) && dig_en[idx] && (pwm_q <= bright);
`else
    logic unused_bright;
    assign unused_bright = ^bright;
    assign lit           = (state == ON) && dig_en[idx];
`endif

    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;
        if (load) begin
            shadow_d  = seg_in;
            pending_d = 1'b1;
        end
        // A load landing on the boundary itself bypasses the shadow straight into the frame.
        if (frame_end) begin
            if (load) begin
                active_d  = seg_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
        seg_d        = lit ? active_q[{idx, 3'b000} +: 8] : SEG_OFF;
        dig_d        = lit ? dig_sel(idx) : DIG_OFF;
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef SEG7_DIM_EN
    always_ff @(posedge clk) begin
        if (rst) pwm_q <= 3'd0;
        else     pwm_q <= pwm_d;
    end
`endif

    assign seg        = seg_q;
    assign dig        = dig_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with SCAN_DIV=10, BLANK_CYCLES=2 (40-cycle frames).
// Edge k after reset release shows slot k/10 mod 4, lit when k mod 10 >= 2; frame_tick at k mod 40 == 39.
module tb_seg7_scan_mux;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        load   = 1'b0;
    logic [31:0] seg_in = 32'h0;
    logic [3:0]  dig_en = 4'hF;
    logic [2:0]  bright = 3'd7;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        frame_tick;

    int          n_chk    = 0;
    int          n_err    = 0;
    int          k        = 0;
    bit          checking = 1'b0;
    logic [31:0] exp_act  = 32'h0;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .SCAN_DIV     (10),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .load       (load),
        .dig_en     (dig_en),
        .bright     (bright),
        .seg        (seg),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    // Expected {seg, dig, frame_tick} after edge kk, given the pattern the bench expects to be active.
    function automatic logic [12:0] exp_pins(input int kk);
        int         d;
        logic       on;
        logic [7:0] s;
        logic [3:0] dg;
        d  = (kk / 10) % 4;
        on = ((kk % 10) >= 2) && dig_en[d];
`ifdef SEG7_DIM_EN
        on = on && ((kk % 8) <= int'(bright));
`endif
        s  = 8'h00;
        dg = 4'hF;
        if (on) begin
            s     = exp_act[d*8 +: 8];
            dg[d] = 1'b0;
        end
        return {s, dg, ((kk % 40) == 39)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (checking) begin
            chk("pins", {19'b0, seg, dig, frame_tick}, {19'b0, exp_pins(k)});
            chk("onecold", 32'($countones(~dig) <= 1), 32'd1);
            chk("dark_seg", 32'((dig != 4'hF) || (seg == 8'h00)), 32'd1);
            k++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_load(input logic [31:0] v);
        load   = 1'b1;
        seg_in = v;
        tick();
        load   = 1'b0;
    endtask

    initial begin
        run(3);
        chk("rst_seg", 32'(seg), 32'h00);
        chk("rst_dig", 32'(dig), 32'hF);
        chk("rst_ftick", 32'(frame_tick), 32'h0);
        chk("rst_cnt", 32'(dut.u_timer.cnt_q), 32'h0);
        chk("rst_idx", 32'(dut.u_timer.idx_q), 32'h0);

        // Frame 1 dark, loaded pattern appears from frame 2.
        rst      = 1'b0;
        checking = 1'b1;
        pulse_load(32'h3F06_5B4F);
        chk("pending_set", 32'(dut.pending_q), 32'h1);
        run(39);
        exp_act = 32'h3F06_5B4F;
        run(40);

        // Mid-frame load waits for the boundary.
        run(15);
        pulse_load(32'hFFFF_FFFF);
        run(24);
        exp_act = 32'hFFFF_FFFF;

        // Two loads in one frame: last one wins.
        run(5);
        pulse_load(32'h1122_3344);
        run(14);
        pulse_load(32'h5566_7788);
        run(19);
        exp_act = 32'h5566_7788;

        // Load exactly on the boundary cycle (k=199) bypasses into the next frame.
        run(39);
        pulse_load(32'hA1B2_C3D4);
        exp_act = 32'hA1B2_C3D4;
        chk("bypass_pend", 32'(dut.pending_q), 32'h0);
        chk("bypass_act", dut.active_q, 32'hA1B2_C3D4);
        run(40);

        dig_en = 4'b1010;
        run(40);
        dig_en = 4'hF;

        bright = 3'd3;
        run(40);
        bright = 3'd7;

        // Pending load then reset at cnt=5 of idx=2: everything including the shadow is discarded.
        run(10);
        pulse_load(32'h9999_9999);
        run(14);
        chk("pre_rst_cnt", 32'(dut.u_timer.cnt_q), 32'd5);
        chk("pre_rst_idx", 32'(dut.u_timer.idx_q), 32'd2);
        rst      = 1'b1;
        checking = 1'b0;
        tick();
        chk("mid_rst_cnt", 32'(dut.u_timer.cnt_q), 32'h0);
        chk("mid_rst_idx", 32'(dut.u_timer.idx_q), 32'h0);
        chk("mid_rst_act", dut.active_q, 32'h0);
        chk("mid_rst_pend", 32'(dut.pending_q), 32'h0);
        tick();
        chk("mid_rst_seg", 32'(seg), 32'h00);
        chk("mid_rst_dig", 32'(dig), 32'hF);
        chk("mid_rst_ftick", 32'(frame_tick), 32'h0);

        rst      = 1'b0;
        k        = 0;
        exp_act  = 32'h0;
        checking = 1'b1;
        run(80);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
